// File: rtl/mmio_input_port.sv
// ---------------------------------------------------------------------------
// mmio_input_port
//
// Memory-mapped input peripheral for the slide switches and pushbuttons.
// Every raw input is synchronised and debounced. Three read-only or W1C
// registers expose the result to the core's load/store path.
//
//   +0  SW_DATA   {22'b0, debounced switches}            read-only
//   +4  KEY_DATA  {28'b0, debounced pressed keys}        read-only
//   +8  KEY_EDGE  {28'b0, sticky press flags}            write-1-to-clear
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable synced cycles needed to accept a new
//                    input level (>= 2)
//   BASE_ADDR        byte address of SW_DATA (word aligned)
//
// Ports
//   clk      single clock, all state on the rising edge
//   reset    asynchronous, active-high
//   Address  byte address from the ALU
//   DataWr   store data
//   MemWr    store strobe
//   SW       raw slide switches (asynchronous, active-high)
//   KEY      raw pushbuttons (asynchronous, active-low)
//   hit      Address selects one of the three registers
//   DataRd   read data for the load mux (zero when not hit)
//   irq      any sticky press flag pending
// ---------------------------------------------------------------------------
module mmio_input_port #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] BASE_ADDR       = 32'hFFFFFFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        MemWr,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic        hit,
  output logic [31:0] DataRd,
  output logic        irq
);

  localparam int NUM_SW = 10;
  localparam int NUM_KEY = 4;
  localparam int NUM_IN = NUM_SW + NUM_KEY;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [31:0] ADDR_SW   = BASE_ADDR;
  localparam logic [31:0] ADDR_KEY  = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_EDGE = BASE_ADDR + 32'd8;

  // Synchronisers hold raw polarity. The key bits reset to 1 (the raw
  // released level) so that a cleared chain never looks like a press.
  localparam logic [NUM_IN-1:0] SYNC_IDLE = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

  logic [NUM_IN-1:0] sync1_reg;
  logic [NUM_IN-1:0] sync2_reg;
  logic [NUM_IN-1:0] synced;
  logic [NUM_IN-1:0] deb_level;
  logic [NUM_IN-1:0] deb_level_next;
  logic [NUM_KEY-1:0] edge_reg;
  logic [NUM_KEY-1:0] edge_next;
  logic [NUM_KEY-1:0] key_rise;
  logic [NUM_KEY-1:0] edge_clr;
  logic unused_data_hi;

  // Two-flop synchroniser chain for all 14 inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= SYNC_IDLE;
      sync2_reg <= SYNC_IDLE;
    end else begin
      sync1_reg <= {KEY, SW};
      sync2_reg <= sync1_reg;
    end
  end

  // Keys become active-high (pressed = 1) after synchronisation.
  assign synced = {~sync2_reg[NUM_IN-1:NUM_SW], sync2_reg[NUM_SW-1:0]};

  // Per-input debouncer. The counter measures how long the synced level has
  // disagreed with the accepted level. Any agreement restarts it, so a glitch
  // shorter than DEBOUNCE_CYCLES can never reach the terminal count.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          deb_reg;
      logic          deb_next;

      always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (synced[gi] == deb_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          deb_next = synced[gi];
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          deb_reg <= deb_next;
        end
      end

      assign deb_level[gi]      = deb_reg;
      assign deb_level_next[gi] = deb_next;
    end
  endgenerate

  // A press is flagged in the same cycle the debounced key rises. This is
  // why the rise is taken from the next-state value.
  assign key_rise = deb_level_next[NUM_IN-1:NUM_SW] & ~deb_level[NUM_IN-1:NUM_SW];

  assign edge_clr = (MemWr && (Address == ADDR_EDGE)) ? DataWr[NUM_KEY-1:0] : '0;

  // Clear is applied first and the set is ORed in afterwards, so a
  // simultaneous set wins.
  assign edge_next = (edge_reg & ~edge_clr) | key_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_reg <= '0;
    end else begin
      edge_reg <= edge_next;
    end
  end

  assign irq = |edge_reg;

  // Only the low nibble of the store data has meaning.
  assign unused_data_hi = ^DataWr[31:NUM_KEY];

  // Address decode and read mux.
  always_comb begin
    hit    = 1'b0;
    DataRd = 32'h0;
    if (Address == ADDR_SW) begin
      hit    = 1'b1;
      DataRd = {22'b0, deb_level[NUM_SW-1:0]};
    end else if (Address == ADDR_KEY) begin
      hit    = 1'b1;
      DataRd = {28'b0, deb_level[NUM_IN-1:NUM_SW]};
    end else if (Address == ADDR_EDGE) begin
      hit    = 1'b1;
      DataRd = {28'b0, edge_reg};
    end
  end

endmodule

// File: tb/tb_mmio_input_port.sv
// ---------------------------------------------------------------------------
// tb_mmio_input_port
//
// Scoreboard bench for mmio_input_port with DEBOUNCE_CYCLES = 4.
//
// For every cycle, the stimulus process drives the bus and the raw inputs.
// It then pushes the expected {hit, DataRd, irq} into a queue. A separate
// monitor pops and compares on the falling edge.
//
// Directed sections use constant expectations. The random section uses a
// behavioural model: an input is accepted once its two-cycle-delayed sample
// has shown the opposite level for the last D samples.
// ---------------------------------------------------------------------------
module tb_mmio_input_port;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'hFFFFFFF0;
  localparam logic [31:0] A0   = BASE;
  localparam logic [31:0] A4   = BASE + 32'd4;
  localparam logic [31:0] A8   = BASE + 32'd8;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic        mem_wr;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic        hit;
  logic [31:0] data_rd;
  logic        irq;

  mmio_input_port #(
    .DEBOUNCE_CYCLES(D),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(address),
    .DataWr(data_wr),
    .MemWr(mem_wr),
    .SW(sw),
    .KEY(key),
    .hit(hit),
    .DataRd(data_rd),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Held stimulus levels used by the cycle tasks.
  logic       cur_rst;
  logic [9:0] cur_sw;
  logic [3:0] cur_key;

  // ---------------- behavioural reference model ----------------
  bit [13:0] m_deb;     // accepted levels: [9:0] switches, [13:10] pressed keys
  bit [3:0]  m_edge;
  bit [13:0] m_dly[$];  // raw samples not yet visible (two-cycle delay)
  bit [13:0] m_win[$];  // last D visible samples

  task automatic model_clear();
    m_deb  = '0;
    m_edge = '0;
    m_dly  = '{14'h0, 14'h0};
    m_win.delete();
    for (int k = 0; k < D; k++) m_win.push_back(14'h0);
  endtask

  task automatic model_tick();
    bit [13:0] cur;
    bit [13:0] seen;
    bit [13:0] nd;
    bit [3:0]  clr;
    bit        all_diff;
    cur  = {~key, sw};
    seen = m_dly.pop_front();
    m_dly.push_back(cur);
    m_win.push_back(seen);
    if (m_win.size() > D) void'(m_win.pop_front());
    nd = m_deb;
    for (int i = 0; i < 14; i++) begin
      all_diff = 1'b1;
      foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all_diff = 1'b0;
      if (all_diff) nd[i] = ~m_deb[i];
    end
    clr    = (mem_wr && address == A8) ? data_wr[3:0] : 4'h0;
    m_edge = (m_edge & ~clr) | (nd[13:10] & ~m_deb[13:10]);
    m_deb  = nd;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == A0) return {22'h0, m_deb[9:0]};
    if (a == A4) return {28'h0, m_deb[13:10]};
    if (a == A8) return {28'h0, m_edge};
    return 32'h0;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    @(posedge clk);
    if (reset) model_clear();
    else model_tick();
    #1;
    reset   = cur_rst;
    address = a;
    mem_wr  = wr;
    data_wr = wd;
    sw      = cur_sw;
    key     = cur_key;
    if (cur_rst) model_clear();
    #1;
  endtask

  // One cycle with its expectation taken from the reference model.
  task automatic cyc(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                     input string nm);
    exp_t e;
    drive(a, wr, wd);
    e.addr = a;
    e.hit  = (a == A0) || (a == A4) || (a == A8);
    e.data = model_rd(a);
    e.irq  = |m_edge;
    e.name = nm;
    sb.push_back(e);
  endtask

  // One cycle with a constant expectation.
  task automatic cyc_c(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input logic c_hit, input logic [31:0] c_data, input logic c_irq,
                       input string nm);
    exp_t e;
    drive(a, wr, wd);
    e.addr = a;
    e.hit  = c_hit;
    e.data = c_data;
    e.irq  = c_irq;
    e.name = nm;
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("txn %-10s addr=%h hit=%b rd=%h irq=%b", e.name, e.addr, hit, data_rd, irq);
        n_checks += 3;
        if (hit !== e.hit) begin
          n_fail++;
          $display("FAIL %s hit: got %b expected %b (addr %h)", e.name, hit, e.hit, e.addr);
        end
        if (data_rd !== e.data) begin
          n_fail++;
          $display("FAIL %s DataRd: got %h expected %h (addr %h)", e.name, data_rd, e.data, e.addr);
        end
        if (irq !== e.irq) begin
          n_fail++;
          $display("FAIL %s irq: got %b expected %b", e.name, irq, e.irq);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a;
    int          k;
    reset   = 1'b1;
    address = A0;
    data_wr = 32'h0;
    mem_wr  = 1'b0;
    sw      = 10'h0;
    key     = 4'hF;
    model_clear();
    cur_rst = 1'b1;
    cur_sw  = 10'h2A5;
    cur_key = 4'hF;

    // Reset state, with switches already set.
    repeat (3) cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "rst");

    // Switch latency measured from reset release.
    cur_rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "sw_wait");
    repeat (2) cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h2A5, 1'b0, "sw_lat");

    // Decode boundaries and read-only registers.
    cyc_c(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "disp_addr");
    cyc_c(BASE + 32'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "unaligned");
    cyc_c(A0, 1'b1, 32'h0, 1'b1, 32'h2A5, 1'b0, "wr_sw");
    cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h2A5, 1'b0, "sw_keep");
    cyc_c(A4, 1'b1, 32'hF, 1'b1, 32'h0, 1'b0, "wr_key");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "edge_idle");

    // Short key glitch is rejected.
    cur_key = 4'b1110;
    repeat (3) cyc_c(A4, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "glitch");
    cur_key = 4'hF;
    for (int i = 0; i < 8; i++)
      cyc_c((i % 2 == 0) ? A4 : A8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "glitch_chk");

    // Held press of KEY[2], then release.
    cur_key = 4'b1011;
    for (int i = 0; i < 6; i++) cyc_c(A4, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "press_wait");
    repeat (2) cyc_c(A4, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, "press");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, "edge_set");
    cur_key = 4'hF;
    for (int i = 0; i < 6; i++) cyc_c(A4, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, "rel_wait");
    repeat (2) cyc_c(A4, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "release");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, "edge_keep");

    // Write-1-to-clear behaviour.
    cur_key = 4'b1110;
    repeat (8) cyc(A8, 1'b0, 32'h0, "press0");
    cur_key = 4'hF;
    repeat (8) cyc(A4, 1'b0, 32'h0, "rel0");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h5, 1'b1, "edge5");
    cyc_c(A8, 1'b1, 32'h1, 1'b1, 32'h5, 1'b1, "w1c_b0");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, "after_w1c");
    cyc_c(A8, 1'b1, 32'hFFFFFFF0, 1'b1, 32'h4, 1'b1, "w1c_hi");
    cyc_c(A8, 1'b1, 32'hF, 1'b1, 32'h4, 1'b1, "w1c_all");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "cleared");

    // Clear and set of the same bit in one cycle: the set wins.
    cur_key = 4'b1101;
    for (int i = 0; i < 5; i++) cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "p1_wait");
    cyc_c(A8, 1'b1, 32'h2, 1'b1, 32'h0, 1'b0, "w1c_race");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h2, 1'b1, "set_wins");
    cur_key = 4'hF;
    repeat (7) cyc(A4, 1'b0, 32'h0, "rel1");
    cyc(A8, 1'b1, 32'hF, "clr1");
    cyc(A8, 1'b0, 32'h0, "clr1_chk");

    // Reset during a pending change, with a key held through the reset.
    cur_sw  = 10'h155;
    cur_key = 4'b1110;
    repeat (3) cyc(A0, 1'b0, 32'h0, "pre_rst");
    cur_rst = 1'b1;
    repeat (2) cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "mid_rst");
    cur_rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, "rq_wait");
    cyc_c(A0, 1'b0, 32'h0, 1'b1, 32'h155, 1'b1, "requal");
    cyc_c(A8, 1'b0, 32'h0, 1'b1, 32'h1, 1'b1, "held_edge");
    cur_key = 4'hF;
    repeat (8) cyc(A4, 1'b0, 32'h0, "rel_held");
    cyc(A8, 1'b1, 32'hF, "clr_held");

    // Randomised traffic checked against the reference model.
    for (int n = 0; n < 700; n++) begin
      cur_rst = ($urandom % 250 == 0);
      k = $urandom % 8;
      if (k == 0) cur_sw = cur_sw ^ (10'h1 << ($urandom % 10));
      if (k == 1) cur_key = cur_key ^ (4'h1 << ($urandom % 4));
      case ($urandom % 8)
        0: a = A0;
        1: a = A4;
        2, 3: a = A8;
        4: a = 32'hFFFFFFFC;
        5: a = BASE + 32'($urandom % 4);
        6: a = A4 + 32'($urandom % 4);
        default: a = $urandom;
      endcase
      cyc(a, ($urandom % 4 == 0), $urandom, "rand");
    end

    // Drain the scoreboard.
    cur_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_input_port.md
MMIO_INPUT_PORT -- requirements
Module: mmio_input_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable synced cycles required to accept a new input level (minimum 2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'hFFFFFFF0, meaning word address of register 0; registers occupy BASE_ADDR+0/+4/+8, disjoint from display address 0xFFFFFFFC.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Address  input  32  byte address from ALU result.
REQ-006 DataWr  input  32  store data (rs2).
REQ-007 MemWr  input  1  store strobe (DMWr).
REQ-008 SW  input  10  raw slide switches, asynchronous, active-high.
REQ-009 KEY  input  4  raw pushbuttons, asynchronous, active-low.
REQ-010 hit  output  1  Address selects one of the three registers.
REQ-011 DataRd  output  32  read data for load mux.
REQ-012 irq  output  1  any pending key-press flag.

Function
REQ-013 Register map SHALL be: +0 SW_DATA = {22'b0, debounced SW}, RO; +4 KEY_DATA = {28'b0, debounced pressed keys (inverted KEY)}, RO; +8 KEY_EDGE = {28'b0, sticky press flags}, W1C.
REQ-014 hit SHALL be combinational: 1 iff Address equals BASE_ADDR, BASE_ADDR+4 or BASE_ADDR+8; any other address, including unaligned, gives hit=0.
REQ-015 DataRd SHALL be combinational: selected register when hit=1, else 32'h0.
REQ-016 Each of the 14 inputs SHALL pass a two-flop synchronizer; KEY inverted after sync (pressed = 1).
REQ-017 Per input: counter clears whenever synced level equals debounced level; otherwise increments each cycle.
REQ-018 When counter = DEBOUNCE_CYCLES-1 and levels still differ, debounced SHALL take synced level and counter SHALL clear.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL never change the debounced level.
REQ-020 Latency: stable raw change visible on SW_DATA/KEY_DATA exactly 2+DEBOUNCE_CYCLES rising edges after the first sampling edge.
REQ-021 KEY_EDGE[i] SHALL set in the same cycle debounced key i goes 0->1; release (1->0) does not affect it.
REQ-022 MemWr=1 with Address=BASE_ADDR+8 SHALL clear each KEY_EDGE bit where DataWr[i]=1 at next edge; DataWr[31:4] ignored.
REQ-023 Set and clear of the same bit in one cycle: set SHALL win (bit stays 1).
REQ-024 Writes to +0/+4 SHALL be ignored with no side effect; hit still 1.
REQ-025 irq SHALL equal OR of KEY_EDGE[3:0], registered-state driven, no combinational path from Address.
REQ-026 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); no wrap occurs since it clears at DEBOUNCE_CYCLES-1.

Reset
REQ-027 reset=1 SHALL immediately clear synchronizers, counters, debounced SW to 0, debounced keys to 0 (released), KEY_EDGE to 0; irq=0.
REQ-028 Reset mid-debounce SHALL abort the pending change; after release, input is re-qualified from zero count.
REQ-029 Deassertion with keys already held SHALL set KEY_EDGE after 2+DEBOUNCE_CYCLES cycles (treated as new press).

Verification (DEBOUNCE_CYCLES=4)
REQ-030 SW=10'h2A5 held from reset release -> read BASE_ADDR returns 32'h000002A5 at cycle 6, 32'h0 before.
REQ-031 KEY[0] low for 3 cycles then high -> KEY_DATA and KEY_EDGE stay 0, irq=0.
REQ-032 KEY[2] low held -> KEY_DATA=32'h4, KEY_EDGE=32'h4, irq=1 at cycle 6; release -> KEY_DATA=0, KEY_EDGE still 32'h4.
REQ-033 KEY_EDGE=32'h5, store 32'h1 to BASE_ADDR+8 -> KEY_EDGE=32'h4, irq=1; store 32'hF -> 0, irq=0.
REQ-034 W1C of bit 1 in same cycle as KEY[1] debounced press -> KEY_EDGE[1]=1.
REQ-035 Address=0xFFFFFFFC or BASE_ADDR+2 -> hit=0, DataRd=0; store to BASE_ADDR -> SW_DATA unchanged.
